lsu_issue_queue: RTL and testbench

In-order load/store issue queue sitting directly upstream of the load-store unit. It accepts load/store instructions from dispatch with possibly-unready source operands and captures operand values broadcast on the common data bus (CDB). It issues the oldest instruction to the LSU once its operands are ready and the LSU is not busy. Program order of memory operations is preserved, so no address disambiguation is needed downstream.

---
 rtl/lsu_issue_queue_pkg.sv | 21 ++
 rtl/lsu_issue_queue_if.sv | 49 ++++
 rtl/lsq_operand_slot.sv | 59 +++++
 rtl/lsu_issue_queue.sv | 137 +++++++++++++
 tb/tb_lsu_issue_queue.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_issue_queue_pkg.sv
// Shared ISA constants and helpers for the LSU issue queue.
package lsu_issue_queue_pkg;

  // ROB tag width, common with the ROB and CDB.
  localparam int unsigned TAG_LEN = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  // Loads have no rs2 operand, so their rs2 slot is marked ready at dispatch.
  function automatic logic is_load(input logic [6:0] opcode);
    return opcode == OP_LOAD;
  endfunction

endpackage

// File: rtl/lsu_issue_queue_if.sv
// Dispatch, CDB, flush and LSU-side signals of the LSU issue queue.
interface lsu_issue_queue_if #(
  parameter int unsigned ADDR_LEN = 2
) ();
  import lsu_issue_queue_pkg::*;

  logic               flush_i;
  logic               dispatch_valid_i;
  logic               dispatch_ready_o;
  logic [31:0]        dispatch_pc_i;
  logic [31:0]        dispatch_inst_i;
  logic [TAG_LEN-1:0] dispatch_tag_i;
  logic               rs1_ready_i;
  logic               rs2_ready_i;
  logic [TAG_LEN-1:0] rs1_tag_i;
  logic [TAG_LEN-1:0] rs2_tag_i;
  logic [31:0]        rs1_value_i;
  logic [31:0]        rs2_value_i;
  logic               cdb_valid_i;
  logic [TAG_LEN-1:0] cdb_tag_i;
  logic [31:0]        cdb_value_i;
  logic               lsu_busy_i;
  logic               lsu_request_o;
  logic [31:0]        lsu_pc_o;
  logic [31:0]        lsu_inst_o;
  logic [31:0]        lsu_rs1_value_o;
  logic [31:0]        lsu_rs2_value_o;
  logic [TAG_LEN-1:0] lsu_tag_o;
  logic [ADDR_LEN:0]  count_o;

  // Queue side.
  modport slave (
    input  flush_i, dispatch_valid_i, dispatch_pc_i, dispatch_inst_i, dispatch_tag_i,
           rs1_ready_i, rs2_ready_i, rs1_tag_i, rs2_tag_i, rs1_value_i, rs2_value_i,
           cdb_valid_i, cdb_tag_i, cdb_value_i, lsu_busy_i,
    output dispatch_ready_o, lsu_request_o, lsu_pc_o, lsu_inst_o, lsu_rs1_value_o,
           lsu_rs2_value_o, lsu_tag_o, count_o
  );

  // Dispatch/CDB/LSU driver side.
  modport master (
    output flush_i, dispatch_valid_i, dispatch_pc_i, dispatch_inst_i, dispatch_tag_i,
           rs1_ready_i, rs2_ready_i, rs1_tag_i, rs2_tag_i, rs1_value_i, rs2_value_i,
           cdb_valid_i, cdb_tag_i, cdb_value_i, lsu_busy_i,
    input  dispatch_ready_o, lsu_request_o, lsu_pc_o, lsu_inst_o, lsu_rs1_value_o,
           lsu_rs2_value_o, lsu_tag_o, count_o
  );

endinterface

// File: rtl/lsq_operand_slot.sv
// One source operand of a queue entry: ready flag, producer tag and value,
// loaded at dispatch (with same-cycle CDB bypass) and woken up by the CDB.
module lsq_operand_slot
  import lsu_issue_queue_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               rdy_i,
  input  logic [TAG_LEN-1:0] tag_i,
  input  logic [31:0]        value_i,
  input  logic               watch_i,
  input  logic               cdb_valid_i,
  input  logic [TAG_LEN-1:0] cdb_tag_i,
  input  logic [31:0]        cdb_value_i,
  output logic               rdy_o,
  output logic [31:0]        value_o
);

  logic               rdy_q, rdy_d;
  logic [TAG_LEN-1:0] tag_q, tag_d;
  logic [31:0]        value_q, value_d;

  // Next state: dispatch load with bypass, else CDB capture while the entry is live.
  always_comb begin
    rdy_d   = rdy_q;
    tag_d   = tag_q;
    value_d = value_q;
    if (load_i) begin
      rdy_d   = rdy_i;
      tag_d   = tag_i;
      value_d = value_i;
      if (!rdy_i && cdb_valid_i && (cdb_tag_i == tag_i)) begin
        rdy_d   = 1'b1;
        value_d = cdb_value_i;
      end
    end else if (watch_i && !rdy_q && cdb_valid_i && (cdb_tag_i == tag_q)) begin
      rdy_d   = 1'b1;
      value_d = cdb_value_i;
    end
  end

  // Operand state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rdy_q   <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      rdy_q   <= rdy_d;
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  assign rdy_o   = rdy_q;
  assign value_o = value_q;

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue: circular buffer that captures CDB results
// and issues only the oldest entry to the LSU once its operands are ready.
module lsu_issue_queue
  import lsu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_LEN = 2
) (
  input logic                  clk_i,
  input logic                  reset_i,
  lsu_issue_queue_if.slave     bus_io
);

  localparam logic [ADDR_LEN:0] CountFull = (ADDR_LEN + 1)'(DEPTH);

  logic [ADDR_LEN-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_LEN:0]   count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;

  logic [31:0]        pc_q   [DEPTH];
  logic [31:0]        inst_q [DEPTH];
  logic [TAG_LEN-1:0] tag_q  [DEPTH];

  logic [DEPTH-1:0] wr_en;
  logic [DEPTH-1:0] rs1_rdy, rs2_rdy;
  logic [31:0]      rs1_val [DEPTH];
  logic [31:0]      rs2_val [DEPTH];

  logic dispatch_ready, dispatch, issue, rs2_ready_in;

  assign dispatch_ready = (count_q != CountFull);
  assign dispatch       = bus_io.dispatch_valid_i && dispatch_ready && !bus_io.flush_i;
  assign issue          = valid_q[head_q] && rs1_rdy[head_q] && rs2_rdy[head_q] &&
                          !bus_io.lsu_busy_i && !bus_io.flush_i;
  assign rs2_ready_in   = bus_io.rs2_ready_i || is_load(bus_io.dispatch_inst_i[6:0]);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign wr_en[i] = dispatch && (tail_q == ADDR_LEN'(i));

    lsq_operand_slot u_rs1 (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .load_i      (wr_en[i]),
      .rdy_i       (bus_io.rs1_ready_i),
      .tag_i       (bus_io.rs1_tag_i),
      .value_i     (bus_io.rs1_value_i),
      .watch_i     (valid_q[i]),
      .cdb_valid_i (bus_io.cdb_valid_i),
      .cdb_tag_i   (bus_io.cdb_tag_i),
      .cdb_value_i (bus_io.cdb_value_i),
      .rdy_o       (rs1_rdy[i]),
      .value_o     (rs1_val[i])
    );

    lsq_operand_slot u_rs2 (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .load_i      (wr_en[i]),
      .rdy_i       (rs2_ready_in),
      .tag_i       (bus_io.rs2_tag_i),
      .value_i     (bus_io.rs2_value_i),
      .watch_i     (valid_q[i]),
      .cdb_valid_i (bus_io.cdb_valid_i),
      .cdb_tag_i   (bus_io.cdb_tag_i),
      .cdb_value_i (bus_io.cdb_value_i),
      .rdy_o       (rs2_rdy[i]),
      .value_o     (rs2_val[i])
    );
  end

  // Pointer, count and valid-bit next state; flush overrides everything.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (dispatch) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + ADDR_LEN'(1);
    end
    if (issue) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ADDR_LEN'(1);
    end
    case ({dispatch, issue})
      2'b10:   count_d = count_q + (ADDR_LEN + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_LEN + 1)'(1);
      default: count_d = count_q;
    endcase
    if (bus_io.flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Queue control state.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload, written at tail on dispatch; cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (dispatch) begin
      pc_q[tail_q]   <= bus_io.dispatch_pc_i;
      inst_q[tail_q] <= bus_io.dispatch_inst_i;
      tag_q[tail_q]  <= bus_io.dispatch_tag_i;
    end
  end

  assign bus_io.dispatch_ready_o = dispatch_ready;
  assign bus_io.lsu_request_o    = issue;
  assign bus_io.lsu_pc_o         = pc_q[head_q];
  assign bus_io.lsu_inst_o       = inst_q[head_q];
  assign bus_io.lsu_tag_o        = tag_q[head_q];
  assign bus_io.lsu_rs1_value_o  = rs1_val[head_q];
  assign bus_io.lsu_rs2_value_o  = rs2_val[head_q];
  assign bus_io.count_o          = count_q;

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Scoreboard bench for lsu_issue_queue: expected issues are queued at dispatch
// and compared whenever the queue raises lsu_request_o.
module tb_lsu_issue_queue;
  import lsu_issue_queue_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_LEN = 2;
  localparam logic [31:0] LW       = 32'h0040A103;
  localparam logic [31:0] SW       = 32'h0020A023;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  lsu_issue_queue_if #(.ADDR_LEN(ADDR_LEN)) bus ();

  lsu_issue_queue #(
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .bus_io  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        pc;
    logic [31:0]        inst;
    logic [TAG_LEN-1:0] tag;
    logic [31:0]        rs1;
    logic [31:0]        rs2;
    bit                 chk_rs2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_issued = 0;
  int   base;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid_i = 1'b0;
    bus.cdb_valid_i      = 1'b0;
  endtask

  task automatic drive_disp(input logic [31:0] pc, input logic [31:0] inst,
                            input logic [TAG_LEN-1:0] tag,
                            input logic r1rdy, input logic [TAG_LEN-1:0] r1tag,
                            input logic [31:0] r1val,
                            input logic r2rdy, input logic [TAG_LEN-1:0] r2tag,
                            input logic [31:0] r2val);
    bus.dispatch_valid_i = 1'b1;
    bus.dispatch_pc_i    = pc;
    bus.dispatch_inst_i  = inst;
    bus.dispatch_tag_i   = tag;
    bus.rs1_ready_i      = r1rdy;
    bus.rs1_tag_i        = r1tag;
    bus.rs1_value_i      = r1val;
    bus.rs2_ready_i      = r2rdy;
    bus.rs2_tag_i        = r2tag;
    bus.rs2_value_i      = r2val;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [TAG_LEN-1:0] tag, input logic [31:0] rs1,
                          input logic [31:0] rs2, input bit chk_rs2);
    exp_t e;
    e.pc = pc; e.inst = inst; e.tag = tag; e.rs1 = rs1; e.rs2 = rs2; e.chk_rs2 = chk_rs2;
    sb.push_back(e);
  endtask

  task automatic cdb(input logic [TAG_LEN-1:0] tag, input logic [31:0] value);
    bus.cdb_valid_i = 1'b1;
    bus.cdb_tag_i   = tag;
    bus.cdb_value_i = value;
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so a request seen
  // here is the one that pops at the coming edge.
  always @(negedge clk) begin
    if (bus.lsu_request_o === 1'b1) begin
      n_issued++;
      if (sb.size() == 0) begin
        check_eq("unexpected_issue_sb_size", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check_eq("issue_pc", bus.lsu_pc_o, mon_e.pc);
        check_eq("issue_inst", bus.lsu_inst_o, mon_e.inst);
        check_eq("issue_tag", 32'(bus.lsu_tag_o), 32'(mon_e.tag));
        check_eq("issue_rs1", bus.lsu_rs1_value_o, mon_e.rs1);
        if (mon_e.chk_rs2) check_eq("issue_rs2", bus.lsu_rs2_value_o, mon_e.rs2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.flush_i = 1'b0;
    bus.lsu_busy_i = 1'b0;
    bus.dispatch_pc_i = '0; bus.dispatch_inst_i = '0; bus.dispatch_tag_i = '0;
    bus.rs1_ready_i = 1'b0; bus.rs2_ready_i = 1'b0;
    bus.rs1_tag_i = '0; bus.rs2_tag_i = '0;
    bus.rs1_value_i = '0; bus.rs2_value_i = '0;
    bus.cdb_tag_i = '0; bus.cdb_value_i = '0;
    idle();

    // Reset state.
    reset_n = 1'b0;
    tick(); tick();
    check_eq("rst_count", 32'(bus.count_o), 32'd0);
    check_eq("rst_request", 32'(bus.lsu_request_o), 32'd0);
    check_eq("rst_ready", 32'(bus.dispatch_ready_o), 32'd1);
    check_eq("rst_pc", bus.lsu_pc_o, 32'd0);
    check_eq("rst_inst", bus.lsu_inst_o, 32'd0);
    check_eq("rst_rs1", bus.lsu_rs1_value_o, 32'd0);
    check_eq("rst_rs2", bus.lsu_rs2_value_o, 32'd0);
    check_eq("rst_tag", 32'(bus.lsu_tag_o), 32'd0);
    reset_n = 1'b1;

    // Ready load issues the cycle after dispatch.
    drive_disp(32'h1000, LW, 4'd3, 1'b1, 4'd0, 32'h100, 1'b0, 4'd9, 32'h5555);
    push_exp(32'h1000, LW, 4'd3, 32'h100, 32'h0, 1'b0);
    tick(); idle();
    check_eq("load_count1", 32'(bus.count_o), 32'd1);
    check_eq("load_request", 32'(bus.lsu_request_o), 32'd1);
    tick();
    check_eq("load_count0", 32'(bus.count_o), 32'd0);
    check_eq("load_request_done", 32'(bus.lsu_request_o), 32'd0);

    // Store waits for rs2 from the CDB.
    base = n_issued;
    drive_disp(32'h1004, SW, 4'd8, 1'b1, 4'd0, 32'h200, 1'b0, 4'd5, 32'h0);
    push_exp(32'h1004, SW, 4'd8, 32'h200, 32'hDEADBEEF, 1'b1);
    tick(); idle();
    check_eq("store_wait1", 32'(bus.lsu_request_o), 32'd0);
    tick();
    check_eq("store_wait2", 32'(bus.lsu_request_o), 32'd0);
    cdb(4'd5, 32'hDEADBEEF);
    tick(); idle();
    check_eq("store_no_early", 32'(n_issued - base), 32'd0);
    check_eq("store_request", 32'(bus.lsu_request_o), 32'd1);
    tick();
    check_eq("store_count0", 32'(bus.count_o), 32'd0);

    // Fill while the LSU is busy.
    bus.lsu_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_disp(32'h2000 + 32'(4 * i), (i % 2 == 1) ? SW : LW, TAG_LEN'(i), 1'b1, 4'd0,
                 32'h300 + 32'(i), 1'b1, 4'd0, 32'h400 + 32'(i));
      push_exp(32'h2000 + 32'(4 * i), (i % 2 == 1) ? SW : LW, TAG_LEN'(i), 32'h300 + 32'(i),
               32'h400 + 32'(i), (i % 2 == 1));
      tick();
    end
    idle();
    check_eq("full_count", 32'(bus.count_o), 32'd4);
    check_eq("full_ready", 32'(bus.dispatch_ready_o), 32'd0);
    check_eq("full_busy_no_req", 32'(bus.lsu_request_o), 32'd0);
    drive_disp(32'h2100, LW, 4'd9, 1'b1, 4'd0, 32'h999, 1'b1, 4'd0, 32'h0);
    tick();
    check_eq("full_refuse", 32'(bus.count_o), 32'd4);
    // Issue pops but the refused dispatch must not pass through.
    bus.lsu_busy_i = 1'b0;
    tick(); idle();
    check_eq("full_no_passthru", 32'(bus.count_o), 32'd3);
    tick();
    check_eq("drain_count2", 32'(bus.count_o), 32'd2);
    tick();
    check_eq("drain_count1", 32'(bus.count_o), 32'd1);
    tick();
    check_eq("drain_count0", 32'(bus.count_o), 32'd0);

    // Back-to-back dispatch and issue keep occupancy at one.
    for (int i = 0; i < 4; i++) begin
      drive_disp(32'h2200 + 32'(4 * i), LW, TAG_LEN'(10 + i), 1'b1, 4'd0, 32'h500 + 32'(i),
                 1'b0, 4'd0, 32'h0);
      push_exp(32'h2200 + 32'(4 * i), LW, TAG_LEN'(10 + i), 32'h500 + 32'(i), 32'h0, 1'b0);
      tick();
      check_eq("stream_count", 32'(bus.count_o), 32'd1);
    end
    idle();
    tick();
    check_eq("stream_count0", 32'(bus.count_o), 32'd0);

    // Unready head blocks a ready younger entry.
    drive_disp(32'h3000, LW, 4'd4, 1'b0, 4'd7, 32'h0, 1'b0, 4'd0, 32'h0);
    push_exp(32'h3000, LW, 4'd4, 32'h77, 32'h0, 1'b0);
    tick();
    drive_disp(32'h3004, SW, 4'd6, 1'b1, 4'd0, 32'h61, 1'b1, 4'd0, 32'h62);
    push_exp(32'h3004, SW, 4'd6, 32'h61, 32'h62, 1'b1);
    tick(); idle();
    base = n_issued;
    tick(); tick();
    check_eq("head_block", 32'(n_issued - base), 32'd0);
    check_eq("head_block_count", 32'(bus.count_o), 32'd2);
    cdb(4'd7, 32'h77);
    tick(); idle();
    check_eq("head_first_req", 32'(bus.lsu_request_o), 32'd1);
    check_eq("head_first_tag", 32'(bus.lsu_tag_o), 32'd4);
    tick();
    check_eq("younger_req", 32'(bus.lsu_request_o), 32'd1);
    check_eq("younger_tag", 32'(bus.lsu_tag_o), 32'd6);
    tick();
    check_eq("head_count0", 32'(bus.count_o), 32'd0);

    // Dispatch-cycle CDB bypass.
    drive_disp(32'h3100, LW, 4'd1, 1'b0, 4'd2, 32'h0, 1'b0, 4'd0, 32'h0);
    cdb(4'd2, 32'h44);
    push_exp(32'h3100, LW, 4'd1, 32'h44, 32'h0, 1'b0);
    tick(); idle();
    check_eq("bypass_req", 32'(bus.lsu_request_o), 32'd1);
    check_eq("bypass_rs1", bus.lsu_rs1_value_o, 32'h44);
    tick();

    // Flush with three entries queued.
    bus.lsu_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_disp(32'h4000 + 32'(4 * i), LW, TAG_LEN'(12 + i), 1'b1, 4'd0, 32'h600, 1'b1,
                 4'd0, 32'h0);
      tick();
    end
    idle();
    check_eq("preflush_count", 32'(bus.count_o), 32'd3);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.lsu_busy_i = 1'b0;
    check_eq("flush_count", 32'(bus.count_o), 32'd0);
    check_eq("flush_no_req", 32'(bus.lsu_request_o), 32'd0);
    check_eq("flush_ready", 32'(bus.dispatch_ready_o), 32'd1);
    drive_disp(32'h4100, SW, 4'd10, 1'b1, 4'd0, 32'h700, 1'b1, 4'd0, 32'h701);
    push_exp(32'h4100, SW, 4'd10, 32'h700, 32'h701, 1'b1);
    tick(); idle();
    check_eq("postflush_req", 32'(bus.lsu_request_o), 32'd1);
    check_eq("postflush_tag", 32'(bus.lsu_tag_o), 32'd10);
    tick();
    check_eq("postflush_count0", 32'(bus.count_o), 32'd0);

    // Reset mid-operation discards queued entries.
    bus.lsu_busy_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_disp(32'h5000 + 32'(4 * i), LW, TAG_LEN'(i), 1'b1, 4'd0, 32'h800, 1'b1, 4'd0,
                 32'h0);
      tick();
    end
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.lsu_busy_i = 1'b0;
    base = n_issued;
    check_eq("midrst_count", 32'(bus.count_o), 32'd0);
    check_eq("midrst_pc", bus.lsu_pc_o, 32'd0);
    tick(); tick();
    check_eq("midrst_no_issue", 32'(n_issued - base), 32'd0);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
